// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions: code geometry, state type, control states
// and the trellis predecessor rule used by the ACS array and the traceback.
package viterbi_pkg;

    localparam int K  = 3;
    localparam int SW = K - 1;
    localparam int S  = 2 ** SW;

    typedef logic [SW-1:0] state_t;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        TRACE  = 2'd1,
        OUTPUT = 2'd2
    } fsm_t;

    // Predecessor of state n along the branch selected by survivor bit b.
    function automatic state_t pred_state(state_t n, logic b);
        return {n[SW-2:0], b};
    endfunction

endpackage

// File: rtl/viterbi_surv_mem.sv
// Survivor memory: one S-bit column per trellis step, synchronous write and
// combinational read so the traceback can hop one column per cycle.
module viterbi_surv_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the fill counter upstream guards stale reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// Survivor-memory traceback: stores one survivor column per accepted step and,
// once the window is full, walks back TB_DEPTH-1 columns to emit one decoded bit.
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int K        = viterbi_pkg::K,
    parameter int TB_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2**(K-1)-1:0]   in_surv,
    input  logic [K-2:0]          in_best_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit
);

    localparam int SWL = K - 1;
    localparam int SL  = 2 ** SWL;
    localparam int AW  = $clog2(TB_DEPTH);
    localparam int FW  = $clog2(TB_DEPTH + 1);

    fsm_t            state_reg;
    logic [AW-1:0]   wptr_reg;
    logic [AW-1:0]   rptr_reg;
    logic [AW-1:0]   step_reg;
    logic [FW-1:0]   fill_reg;
    logic [SWL-1:0]  tb_state_reg;
    logic            out_valid_reg;
    logic            out_bit_reg;

    logic            mem_we;
    logic [SL-1:0]   surv_col;
    logic            surv_bit;
    logic [SWL-1:0]  tb_state_next;
    logic [FW-1:0]   fill_next;

    assign mem_we = (state_reg == ACCEPT) && in_valid;

    viterbi_surv_mem #(
        .DEPTH (TB_DEPTH),
        .WIDTH (SL)
    ) u_surv_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_reg),
        .wdata (in_surv),
        .raddr (rptr_reg),
        .rdata (surv_col)
    );

    // One trellis hop backwards: shift the survivor bit in as the new LSB.
    assign surv_bit      = surv_col[tb_state_reg];
    assign tb_state_next = {tb_state_reg[SWL-2:0], surv_bit};

    assign fill_next = (fill_reg == FW'(TB_DEPTH)) ? fill_reg : fill_reg + FW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ACCEPT;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            step_reg      <= '0;
            fill_reg      <= '0;
            tb_state_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_bit_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ACCEPT: begin
                    if (in_valid) begin
                        tb_state_reg <= in_best_state;
                        rptr_reg     <= wptr_reg;
                        wptr_reg     <= wptr_reg + AW'(1);
                        fill_reg     <= fill_next;
                        if (fill_next == FW'(TB_DEPTH)) begin
                            state_reg <= TRACE;
                            step_reg  <= '0;
                        end
                    end
                end
                TRACE: begin
                    tb_state_reg <= tb_state_next;
                    rptr_reg     <= rptr_reg - AW'(1);
                    step_reg     <= step_reg + AW'(1);
                    // The final hop lands on the column written TB_DEPTH-1 steps ago.
                    if (step_reg == AW'(TB_DEPTH - 2)) begin
                        out_bit_reg   <= tb_state_next[SWL-1];
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ACCEPT;
                    end
                end
                default: begin
                    state_reg <= ACCEPT;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ACCEPT);
    assign out_valid = out_valid_reg;
    assign out_bit   = out_bit_reg;

endmodule
